// File: rtl/hier_logic_pipe.sv
// Elastic pipeline computing a bitwise AND/OR/XOR/NAND of two operands.
// Each stage has a valid bit; bubbles collapse and backpressure ripples combinationally.
module hier_logic_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic [15:0]      out_count
);

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] ready;
  logic [WIDTH-1:0]  result;
  logic              out_hs;

  always_comb begin
    result = '0;
    unique case (op)
      2'd0: result = a & b;
      2'd1: result = a | b;
      2'd2: result = a ^ b;
      2'd3: result = ~(a & b);
    endcase
  end

  // Stage k can load when any stage from k to the output is empty, or the output drains.
  for (genvar k = 0; k < STAGES; k++) begin : g_ready
    assign ready[k] = out_ready | ~(&valid_q[STAGES-1:k]);
  end

  assign in_ready  = rst & ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign c         = data_q[STAGES-1];
  assign out_hs    = out_valid & out_ready;
  assign busy      = |valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      out_count <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      if (ready[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) data_q[0] <= result;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
      if (out_hs) out_count <= out_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hier_logic_pipe.sv
// Directed and random checks of hier_logic_pipe at STAGES=2 and STAGES=1, WIDTH=8,
// with per-instance scoreboards fed at input handshakes and drained at output handshakes.
module tb_hier_logic_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv2, ir2, ov2, or2, busy2;
  logic [7:0] a2, b2, c2;
  logic [1:0] op2;
  logic [15:0] cnt2;

  logic       iv1, ir1, ov1, or1, busy1;
  logic [7:0] a1, b1, c1;
  logic [1:0] op1;
  logic [15:0] cnt1;

  hier_logic_pipe #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .op(op2),
    .out_valid(ov2), .out_ready(or2), .c(c2), .busy(busy2), .out_count(cnt2)
  );

  hier_logic_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op(op1),
    .out_valid(ov1), .out_ready(or1), .c(c1), .busy(busy1), .out_count(cnt1)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  q2[$];
  logic [7:0]  q1[$];
  logic [15:0] exp_cnt2 = '0;
  logic [15:0] exp_cnt1 = '0;
  logic        stall2 = 1'b0;
  logic        stall1 = 1'b0;
  logic [7:0]  held2, held1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs change at posedge+1, so negedge sees exactly what the next posedge will see.
  always @(negedge clk) begin
    if (rst) begin
      chk("cnt2", {16'd0, cnt2}, {16'd0, exp_cnt2});
      if (stall2) begin
        chk("stall2_valid", {31'd0, ov2}, 32'd1);
        chk("stall2_data", {24'd0, c2}, {24'd0, held2});
      end
      stall2 = ov2 && !or2;
      held2  = c2;
      if (ov2 && or2) begin
        chk("sb2_nonempty", {31'd0, q2.size() != 0}, 32'd1);
        if (q2.size() != 0) chk("sb2_data", {24'd0, c2}, {24'd0, q2.pop_front()});
        exp_cnt2++;
      end
      if (iv2 && ir2) q2.push_back(model(a2, b2, op2));

      chk("ir1_rule", {31'd0, ir1}, {31'd0, !ov1 || or1});
      chk("cnt1", {16'd0, cnt1}, {16'd0, exp_cnt1});
      if (stall1) chk("stall1_data", {24'd0, c1}, {24'd0, held1});
      stall1 = ov1 && !or1;
      held1  = c1;
      if (ov1 && or1) begin
        chk("sb1_nonempty", {31'd0, q1.size() != 0}, 32'd1);
        if (q1.size() != 0) chk("sb1_data", {24'd0, c1}, {24'd0, q1.pop_front()});
        exp_cnt1++;
      end
      if (iv1 && ir1) q1.push_back(model(a1, b1, op1));
    end else begin
      stall2 = 1'b0;
      stall1 = 1'b0;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    q2.delete();
    q1.delete();
    exp_cnt2 = '0;
    exp_cnt1 = '0;
  endtask

  initial begin
    int  acc;
    logic hs;
    rst = 1'b1;
    iv2 = 0; a2 = 0; b2 = 0; op2 = 0; or2 = 1;
    iv1 = 0; a1 = 0; b1 = 0; op1 = 0; or1 = 1;
    #1 rst = 1'b0;
    #2;
    chk("rst_ir2", {31'd0, ir2}, 32'd0);
    chk("rst_ov2", {31'd0, ov2}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_c2", {24'd0, c2}, 32'd0);
    chk("rst_cnt2", {16'd0, cnt2}, 32'd0);
    chk("rst_ir1", {31'd0, ir1}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rel_ir2", {31'd0, ir2}, 32'd1);
    chk("rel_ir1", {31'd0, ir1}, 32'd1);

    // Back-to-back ops on F0/3C, results 2 cycles after first handshake.
    iv2 = 1; a2 = 8'hF0; b2 = 8'h3C; op2 = 0;
    step(); op2 = 1;
    step(); op2 = 2;
    chk("b2b_ov", {31'd0, ov2}, 32'd1);
    chk("b2b_and", {24'd0, c2}, 32'h30);
    step(); op2 = 3;
    chk("b2b_or", {24'd0, c2}, 32'hFC);
    step(); iv2 = 0;
    chk("b2b_xor", {24'd0, c2}, 32'hCC);
    step();
    chk("b2b_nand", {24'd0, c2}, 32'hCF);
    step();
    chk("b2b_empty", {31'd0, ov2}, 32'd0);

    // Fill under backpressure: exactly two accepted, then drain in order.
    or2 = 0; iv2 = 1; a2 = 8'hAA; b2 = 8'h0F; op2 = 2;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hs = iv2 && ir2;
      step();
      if (hs) begin
        acc++;
        op2 = (acc == 1) ? 2'd0 : 2'd1;
      end
    end
    chk("full_accepted", acc, 2);
    chk("full_ir", {31'd0, ir2}, 32'd0);
    chk("full_c", {24'd0, c2}, 32'hA5);
    chk("full_busy", {31'd0, busy2}, 32'd1);
    or2 = 1;
    step(); iv2 = 0;
    chk("drain_1", {24'd0, c2}, 32'h0A);
    step();
    chk("drain_2", {24'd0, c2}, 32'hAF);
    step();
    chk("drain_done", {31'd0, ov2}, 32'd0);

    // Random valid/ready traffic; upstream holds payload until accepted.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      hs = iv2 && ir2;
      step();
      if (hs || !iv2) begin
        iv2 = 1'($urandom);
        a2  = 8'($urandom);
        b2  = 8'($urandom);
        op2 = 2'($urandom);
      end
      or2 = 1'($urandom);
    end
    iv2 = 0; or2 = 1;
    for (int i = 0; i < 4; i++) step();
    chk("rand_sb_empty", q2.size(), 0);
    chk("rand_ov_idle", {31'd0, ov2}, 32'd0);

    // Reset with two results in flight.
    or2 = 0; iv2 = 1; a2 = 8'h55; b2 = 8'hFF; op2 = 1;
    step(); op2 = 2;
    step(); iv2 = 0;
    chk("inflight_busy", {31'd0, busy2}, 32'd1);
    #2 do_reset();
    #1;
    chk("mid_rst_ov", {31'd0, ov2}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy2}, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt2}, 32'd0);
    step();
    #2 rst = 1'b1;
    or2 = 1;
    #1 chk("mid_rel_ir", {31'd0, ir2}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale", {31'd0, ov2}, 32'd0);
    end

    // Single-stage instance with out_ready toggling each cycle.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hs = iv1 && ir1;
      step();
      if (hs || !iv1) begin
        iv1 = 1'($urandom);
        a1  = 8'($urandom);
        b1  = 8'($urandom);
        op1 = 2'($urandom);
      end
      or1 = ~or1;
    end
    iv1 = 0; or1 = 1;
    for (int i = 0; i < 3; i++) step();
    chk("s1_sb_empty", q1.size(), 0);

    // Counter wrap: 65535 handshakes to FFFF, one more to 0.
    step();
    #2 do_reset();
    step();
    #2 rst = 1'b1;
    or2 = 1; iv2 = 1;
    for (int i = 0; i < 65535; i++) begin
      a2 = 8'($urandom); b2 = 8'($urandom); op2 = 2'($urandom);
      step();
    end
    iv2 = 0;
    for (int i = 0; i < 3; i++) step();
    chk("cnt_ffff", {16'd0, cnt2}, 32'hFFFF);
    iv2 = 1; a2 = 8'h12; b2 = 8'h34; op2 = 0;
    step(); iv2 = 0;
    for (int i = 0; i < 3; i++) step();
    chk("cnt_wrap", {16'd0, cnt2}, 32'd0);
    chk("wrap_sb_empty", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hier_logic_pipe.md
HIER_LOGIC_PIPE -- requirements
Module: hier_logic_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32: operand and result width in bits, legal values 1 or more.
REQ-002 The module SHALL have parameter STAGES, default 2: pipeline depth in register stages, legal values 1 to 8.
REQ-003 The module SHALL have port clk, input, width 1: single clock; all state updates on the posedge.
REQ-004 The module SHALL have port rst, input, width 1: asynchronous reset, active-low, asserted when 0.
REQ-005 The module SHALL have port in_valid, input, width 1: upstream presents a, b and op.
REQ-006 The module SHALL have port in_ready, output, width 1: block accepts the input this cycle.
REQ-007 The module SHALL have port a, input, width WIDTH: operand A.
REQ-008 The module SHALL have port b, input, width WIDTH: operand B.
REQ-009 The module SHALL have port op, input, width 2: operation select; 0=AND, 1=OR, 2=XOR, 3=NAND.
REQ-010 The module SHALL have port out_valid, output, width 1: result available on c.
REQ-011 The module SHALL have port out_ready, input, width 1: downstream accepts the result.
REQ-012 The module SHALL have port c, output, width WIDTH: registered result.
REQ-013 The module SHALL have port busy, output, width 1: at least one stage holds valid data.
REQ-014 The module SHALL have port out_count, output, width 16: count of completed output handshakes.

Function
REQ-015 An input handshake SHALL occur on a posedge where in_valid and in_ready are both 1.
REQ-016 An output handshake SHALL occur on a posedge where out_valid and out_ready are both 1.
REQ-017 The bitwise op result SHALL be computed from a, b and op at input handshake and captured into stage 1; later stages SHALL carry it unchanged.
REQ-018 Each stage k SHALL hold a valid bit and a WIDTH-bit data register; stage STAGES SHALL drive out_valid and c directly from registers.
REQ-019 Stage k SHALL advance into stage k+1 when stage k+1 is empty or stage k+1 advances in the same cycle; the last stage SHALL empty only on an output handshake.
REQ-020 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances this cycle; the ready chain is combinational from out_ready.
REQ-021 Unstalled latency SHALL be exactly STAGES cycles from input handshake to out_valid=1.
REQ-022 Sustained throughput SHALL be one result per cycle when in_valid=1 and out_ready=1.
REQ-023 Results SHALL leave in input-handshake order; no loss, duplication or reordering.
REQ-024 While out_valid=1 and out_ready=0, c SHALL remain stable and out_valid SHALL remain 1.
REQ-025 Pipeline full (all STAGES valid) with out_ready=0 SHALL force in_ready=0; a simultaneous output handshake and input handshake on a full pipe SHALL both complete.
REQ-026 in_valid=1 with in_ready=0 SHALL NOT capture data; upstream holds.
REQ-027 Bubbles SHALL collapse: an empty stage SHALL be filled from the stage behind it without waiting for out_ready.
REQ-028 out_count SHALL increment by 1 per output handshake and wrap from 16'hFFFF to 0.
REQ-029 busy SHALL be the OR of all stage valid bits.
REQ-030 With STAGES=1 the block SHALL still give full throughput: in_ready = !out_valid || out_ready.

Reset
REQ-031 While rst=0, all stage valid bits, c, and out_count SHALL be 0 immediately, independent of clk.
REQ-032 While rst=0, in_ready SHALL be 0; out_valid and busy SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight data with no output handshake.
REQ-034 On the first posedge after rst returns to 1, in_ready SHALL be 1 and the block SHALL accept input.

Verification
REQ-035 Bench: STAGES=2, WIDTH=8, out_ready=1; send a=8'hF0, b=8'h3C with op=0,1,2,3 back-to-back -> c=8'h30, 8'hFC, 8'hCC, 8'hCF on 4 consecutive cycles, starting 2 cycles after the first handshake.
REQ-036 Bench: fill the pipe with out_ready=0 -> exactly 2 handshakes accepted, then in_ready=0; c holds the first result. Raise out_ready -> results drain in order, one per cycle.
REQ-037 Bench: random in_valid and out_ready for 10000 cycles against a scoreboard -> every result matches and is in order; out_count equals the output handshake count modulo 65536.
REQ-038 Bench: assert rst=0 between clock edges with 2 results in flight -> out_valid, busy and out_count go to 0 immediately; no stale result appears after release.
REQ-039 Bench: STAGES=1 with out_ready toggling every cycle -> no data loss; in_ready matches REQ-030 every cycle.
REQ-040 Bench: preload out_count to 16'hFFFF via 65535 handshakes, then one more handshake -> out_count=0.
